// File: rtl/l1_mem_arbiter.sv
// ---------------------------------------------------------------------------
// l1_mem_arbiter
//
// Shares one Master port between the L1 instruction-cache and L1 data-cache
// miss/refill interfaces. One side owns the port for exactly one
// transaction at a time. Ties are broken round-robin against the side
// granted last. The granted request is latched on the grant edge, so the
// Master sees stable inputs even if the requester changes or drops its
// request mid-transaction. Saturating per-side counters record completed
// transactions for performance debug.
//
// Ports
//   clk, rst            : clock; asynchronous active-low reset
//   I_req/I_addr        : instruction-side request (read-only, type 3'b111)
//   I_write/I_type      : accepted but ignored
//   I_out/I_wait        : instruction-side read data and stall
//   D_req/D_addr/D_write/D_in/D_type : data-side request
//   D_out/D_wait        : data-side read data and stall
//   m_read/m_write/m_type/m_addr/m_wdata : latched request to the Master
//   m_rdata/m_stall     : Master response; m_stall low = completes this cycle
//   cnt_i/cnt_d         : saturating completed-transaction counters
// ---------------------------------------------------------------------------
module l1_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int TYPE_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_req,
  input  logic [DATA_W-1:0] I_addr,
  input  logic              I_write,
  input  logic [TYPE_W-1:0] I_type,
  output logic [DATA_W-1:0] I_out,
  output logic              I_wait,
  input  logic              D_req,
  input  logic [DATA_W-1:0] D_addr,
  input  logic              D_write,
  input  logic [DATA_W-1:0] D_in,
  input  logic [TYPE_W-1:0] D_type,
  output logic [DATA_W-1:0] D_out,
  output logic              D_wait,
  output logic              m_read,
  output logic              m_write,
  output logic [TYPE_W-1:0] m_type,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_stall,
  output logic [CNT_W-1:0]  cnt_i,
  output logic [CNT_W-1:0]  cnt_d
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: D side was granted last
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [TYPE_W-1:0] m_type_q, m_type_d;
  logic [DATA_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [CNT_W-1:0]  cnt_i_q, cnt_i_d;
  logic [CNT_W-1:0]  cnt_d_q, cnt_d_d;

  // The I side is read-only with a fixed type; these inputs carry no meaning.
  logic unused_i_side;
  assign unused_i_side = ^{I_write, I_type};

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_type_d  = m_type_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    cnt_i_d   = cnt_i_q;
    cnt_d_d   = cnt_d_q;

    unique case (state_q)
      IDLE: begin
        // I wins when alone, or on a tie when D was the last one served.
        if (I_req && (!D_req || last_d_q)) begin
          state_d   = GNT_I;
          last_d_d  = 1'b0;
          m_read_d  = 1'b1;
          m_write_d = 1'b0;
          m_type_d  = {TYPE_W{1'b1}};
          m_addr_d  = I_addr;
        end else if (D_req) begin
          state_d   = GNT_D;
          last_d_d  = 1'b1;
          m_read_d  = !D_write;
          m_write_d = D_write;
          m_type_d  = D_type;
          m_addr_d  = D_addr;
          m_wdata_d = D_in;
        end
      end
      GNT_I: begin
        if (!m_stall) begin
          state_d   = IDLE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          if (cnt_i_q != {CNT_W{1'b1}}) cnt_i_d = cnt_i_q + CNT_ONE;
        end
      end
      GNT_D: begin
        if (!m_stall) begin
          state_d   = IDLE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          if (cnt_d_q != {CNT_W{1'b1}}) cnt_d_d = cnt_d_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_type_q  <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      cnt_i_q   <= '0;
      cnt_d_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_type_q  <= m_type_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      cnt_i_q   <= cnt_i_d;
      cnt_d_q   <= cnt_d_d;
    end
  end

  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign m_type  = m_type_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign cnt_i   = cnt_i_q;
  assign cnt_d   = cnt_d_q;

  // Read data is only steered to the owner of the port.
  assign I_out = (state_q == GNT_I) ? m_rdata : '0;
  assign D_out = (state_q == GNT_D) ? m_rdata : '0;

  // A requester with req low never stalls; the owner follows the Master;
  // anyone else waiting for the port is held off.
  assign I_wait = I_req && ((state_q == GNT_I) ? m_stall : 1'b1);
  assign D_wait = D_req && ((state_q == GNT_D) ? m_stall : 1'b1);

endmodule

// File: tb/tb_l1_mem_arbiter.sv
module tb_l1_mem_arbiter;

  localparam int DW = 32;
  localparam int TW = 3;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          I_req, I_write, D_req, D_write, m_stall;
  logic [DW-1:0] I_addr, D_addr, D_in, m_rdata;
  logic [TW-1:0] I_type, D_type;
  logic [DW-1:0] I_out, D_out, m_addr, m_wdata;
  logic          I_wait, D_wait, m_read, m_write;
  logic [TW-1:0] m_type;
  logic [CW-1:0] cnt_i, cnt_d;

  int n_checks = 0;
  int n_fail   = 0;

  l1_mem_arbiter #(.DATA_W(DW), .TYPE_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .I_req(I_req), .I_addr(I_addr), .I_write(I_write), .I_type(I_type),
    .I_out(I_out), .I_wait(I_wait),
    .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in),
    .D_type(D_type), .D_out(D_out), .D_wait(D_wait),
    .m_read(m_read), .m_write(m_write), .m_type(m_type), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_stall(m_stall),
    .cnt_i(cnt_i), .cnt_d(cnt_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic ireq; logic [31:0] iaddr;
    logic dreq; logic dwr; logic [31:0] daddr; logic [31:0] din; logic [2:0] dtype;
    logic stall; logic [31:0] rdata;
    logic erd; logic ewr; logic [31:0] eaddr; logic [2:0] etype; logic [31:0] ewdata;
    logic eiw; logic edw; logic [31:0] eio; logic [31:0] edo;
    logic [3:0] ecnti; logic [3:0] ecntd;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(int ireq, int iaddr, int dreq, int dwr, int daddr,
                              int din, int dtype, int stall, int rdata,
                              int erd, int ewr, int eaddr, int etype, int ewdata,
                              int eiw, int edw, int eio, int edo, int ecnti, int ecntd);
    vec_t v;
    v.ireq = ireq[0];   v.iaddr = iaddr;
    v.dreq = dreq[0];   v.dwr = dwr[0];   v.daddr = daddr; v.din = din;
    v.dtype = dtype[2:0];
    v.stall = stall[0]; v.rdata = rdata;
    v.erd = erd[0];     v.ewr = ewr[0];   v.eaddr = eaddr; v.etype = etype[2:0];
    v.ewdata = ewdata;  v.eiw = eiw[0];   v.edw = edw[0];
    v.eio = eio;        v.edo = edo;
    v.ecnti = ecnti[3:0]; v.ecntd = ecntd[3:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- vector table (one row per clock cycle) ----------------
    // inputs: ireq iaddr dreq dwr daddr din dtype stall rdata
    // expect: rd wr addr type wdata iwait dwait iout dout cnt_i cnt_d
    // I read, three Master stall cycles
    vecs[0]  = mk(1,'h40,0,0,0,0,0, 1,0,                0,0,'h40*0,0,0, 1,0,0,0, 0,0);
    vecs[1]  = mk(1,'h40,0,0,0,0,0, 1,0,                1,0,'h40,7,0, 1,0,0,0, 0,0);
    vecs[2]  = mk(1,'h40,0,0,0,0,0, 1,0,                1,0,'h40,7,0, 1,0,0,0, 0,0);
    vecs[3]  = mk(1,'h40,0,0,0,0,0, 1,0,                1,0,'h40,7,0, 1,0,0,0, 0,0);
    vecs[4]  = mk(1,'h40,0,0,0,0,0, 0,'hDEADBEEF,       1,0,'h40,7,0, 0,0,'hDEADBEEF,0, 0,0);
    vecs[5]  = mk(0,0,0,0,0,0,0, 1,0,                   0,0,'h40,7,0, 0,0,0,0, 1,0);
    // D write; inputs changed after the grant must not reach m_*
    vecs[6]  = mk(0,0,1,1,'h10000004,'h12345678,2, 1,0, 0,0,'h40,7,0, 0,1,0,0, 1,0);
    vecs[7]  = mk(0,0,1,1,'hFFFF0000,0,5, 1,0,          0,1,'h10000004,2,'h12345678, 0,1,0,0, 1,0);
    vecs[8]  = mk(0,0,1,1,'hFFFF0000,0,5, 0,'hAAAA5555, 0,1,'h10000004,2,'h12345678, 0,0,0,'hAAAA5555, 1,0);
    vecs[9]  = mk(0,0,0,0,0,0,0, 1,0,                   0,0,'h10000004,2,'h12345678, 0,0,0,0, 1,1);
    // Tie: I (D served last), one IDLE, D, one IDLE, I
    vecs[10] = mk(1,'h100,1,0,'h200,0,1, 1,0,           0,0,'h10000004,2,'h12345678, 1,1,0,0, 1,1);
    vecs[11] = mk(1,'h100,1,0,'h200,0,1, 0,'h11111111,  1,0,'h100,7,'h12345678, 0,1,'h11111111,0, 1,1);
    vecs[12] = mk(1,'h100,1,0,'h200,0,1, 1,0,           0,0,'h100,7,'h12345678, 1,1,0,0, 2,1);
    vecs[13] = mk(1,'h100,1,0,'h200,0,1, 0,'h22222222,  1,0,'h200,1,0, 1,0,0,'h22222222, 2,1);
    vecs[14] = mk(1,'h100,1,0,'h200,0,1, 1,0,           0,0,'h200,1,0, 1,1,0,0, 2,2);
    vecs[15] = mk(1,'h100,0,0,0,0,0, 0,'h33333333,      1,0,'h100,7,0, 0,0,'h33333333,0, 2,2);
    vecs[16] = mk(0,0,0,0,0,0,0, 1,0,                   0,0,'h100,7,0, 0,0,0,0, 3,2);
    // D read with D_req dropped while granted
    vecs[17] = mk(0,0,1,0,'h300,0,0, 1,0,               0,0,'h100,7,0, 0,1,0,0, 3,2);
    vecs[18] = mk(0,0,0,0,'h300,0,0, 1,0,               1,0,'h300,0,0, 0,0,0,0, 3,2);
    vecs[19] = mk(0,0,0,0,'h300,0,0, 0,'h44444444,      1,0,'h300,0,0, 0,0,0,'h44444444, 3,2);
    vecs[20] = mk(0,0,0,0,0,0,0, 1,0,                   0,0,'h300,0,0, 0,0,0,0, 3,3);

    // ---------------- reset ----------------
    rst = 1'b0;
    I_req = 0; I_addr = '0; I_write = 1'b1; I_type = 3'b000;
    D_req = 0; D_addr = '0; D_write = 0; D_in = '0; D_type = '0;
    m_stall = 1'b1; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset m_read",  32'(m_read), 32'd0);
    chk("reset m_write", 32'(m_write), 32'd0);
    chk("reset m_addr",  m_addr, 32'd0);
    chk("reset m_type",  32'(m_type), 32'd0);
    chk("reset m_wdata", m_wdata, 32'd0);
    chk("reset cnt_i",   32'(cnt_i), 32'd0);
    chk("reset cnt_d",   32'(cnt_d), 32'd0);
    rst = 1'b1;

    // ---------------- table-driven cycles ----------------
    for (int i = 0; i < 21; i++) begin
      I_req = vecs[i].ireq;   I_addr = vecs[i].iaddr;
      D_req = vecs[i].dreq;   D_write = vecs[i].dwr;   D_addr = vecs[i].daddr;
      D_in = vecs[i].din;     D_type = vecs[i].dtype;
      m_stall = vecs[i].stall; m_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d m_read", i),  32'(m_read),  32'(vecs[i].erd));
      chk($sformatf("v%0d m_write", i), 32'(m_write), 32'(vecs[i].ewr));
      chk($sformatf("v%0d m_addr", i),  m_addr,       vecs[i].eaddr);
      chk($sformatf("v%0d m_type", i),  32'(m_type),  32'(vecs[i].etype));
      chk($sformatf("v%0d m_wdata", i), m_wdata,      vecs[i].ewdata);
      chk($sformatf("v%0d I_wait", i),  32'(I_wait),  32'(vecs[i].eiw));
      chk($sformatf("v%0d D_wait", i),  32'(D_wait),  32'(vecs[i].edw));
      chk($sformatf("v%0d I_out", i),   I_out,        vecs[i].eio);
      chk($sformatf("v%0d D_out", i),   D_out,        vecs[i].edo);
      chk($sformatf("v%0d cnt_i", i),   32'(cnt_i),   32'(vecs[i].ecnti));
      chk($sformatf("v%0d cnt_d", i),   32'(cnt_d),   32'(vecs[i].ecntd));
      $display("cycle %0d: rd=%0d wr=%0d addr=%08h type=%0d wdata=%08h iw=%0d dw=%0d iout=%08h dout=%08h ci=%0d cd=%0d",
               i, m_read, m_write, m_addr, m_type, m_wdata, I_wait, D_wait, I_out, D_out, cnt_i, cnt_d);
      next_cycle();
    end

    // ---------------- reset in the middle of a D grant ----------------
    D_req = 1; D_write = 1; D_addr = 'h500; D_in = 'h55; D_type = 3'd3;
    m_stall = 1'b1; m_rdata = 'h99;
    next_cycle();
    @(negedge clk);
    chk("pre-reset m_write", 32'(m_write), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst m_read",  32'(m_read), 32'd0);
    chk("midrst m_write", 32'(m_write), 32'd0);
    chk("midrst m_addr",  m_addr, 32'd0);
    chk("midrst m_wdata", m_wdata, 32'd0);
    chk("midrst m_type",  32'(m_type), 32'd0);
    chk("midrst cnt_i",   32'(cnt_i), 32'd0);
    chk("midrst cnt_d",   32'(cnt_d), 32'd0);
    chk("midrst D_out",   D_out, 32'd0);
    chk("midrst D_wait",  32'(D_wait), 32'd1);
    $display("mid-grant reset: rd=%0d wr=%0d addr=%08h ci=%0d cd=%0d", m_read, m_write, m_addr, cnt_i, cnt_d);
    D_req = 0;
    next_cycle();
    rst = 1'b1;

    // ---------------- tie right after reset: I, D, I ----------------
    I_req = 1; I_addr = 'h600; D_req = 1; D_write = 0; D_addr = 'h700; D_type = 3'd1;
    m_stall = 1'b1; m_rdata = '0;
    @(negedge clk);
    chk("tie idle m_read", 32'(m_read), 32'd0);
    chk("tie idle D_wait", 32'(D_wait), 32'd1);
    next_cycle();
    m_stall = 1'b0; m_rdata = 'h600600;
    @(negedge clk);
    chk("tie first m_addr", m_addr, 32'h600);
    chk("tie first m_read", 32'(m_read), 32'd1);
    chk("tie first D_wait", 32'(D_wait), 32'd1);
    chk("tie first I_out",  I_out, 32'h600600);
    $display("tie grant 1: addr=%08h iout=%08h dw=%0d", m_addr, I_out, D_wait);
    next_cycle();
    m_stall = 1'b1; m_rdata = '0;
    @(negedge clk);
    chk("tie gap m_read", 32'(m_read), 32'd0);
    chk("tie gap D_wait", 32'(D_wait), 32'd1);
    next_cycle();
    m_stall = 1'b0; m_rdata = 'h700700;
    @(negedge clk);
    chk("tie second m_addr", m_addr, 32'h700);
    chk("tie second m_read", 32'(m_read), 32'd1);
    chk("tie second D_out",  D_out, 32'h700700);
    chk("tie second I_wait", 32'(I_wait), 32'd1);
    $display("tie grant 2: addr=%08h dout=%08h iw=%0d", m_addr, D_out, I_wait);
    next_cycle();
    m_stall = 1'b1; m_rdata = '0;
    next_cycle();
    @(negedge clk);
    chk("tie third m_addr", m_addr, 32'h600);
    chk("tie third m_read", 32'(m_read), 32'd1);
    chk("tie third cnt_i",  32'(cnt_i), 32'd1);
    chk("tie third cnt_d",  32'(cnt_d), 32'd1);
    $display("tie grant 3: addr=%08h ci=%0d cd=%0d", m_addr, cnt_i, cnt_d);

    // ---------------- counter saturation: 17 I transactions ----------------
    rst = 1'b0;
    I_req = 1; I_addr = 'h800; D_req = 0; m_stall = 1'b0; m_rdata = 'h1;
    next_cycle();
    rst = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      next_cycle();
      if (k == 28) chk("sat cnt_i after 14", 32'(cnt_i), 32'd14);
      if (k == 30) chk("sat cnt_i after 15", 32'(cnt_i), 32'd15);
    end
    I_req = 0;
    @(negedge clk);
    chk("sat cnt_i after 17", 32'(cnt_i), 32'd15);
    chk("sat cnt_d",          32'(cnt_d), 32'd0);
    $display("saturation: cnt_i=%0d cnt_d=%0d", cnt_i, cnt_d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Shares one AXI Master port between the L1 instruction-cache and L1 data-cache miss/refill request interfaces inside the CPU wrapper. Either cache can own the port for exactly one transaction at a time. Grants are fair round-robin, and the granted request is latched so the Master sees stable inputs. The block also replaces the ad-hoc DM lock, and keeps per-requester saturating transaction counters for performance debug.

## Interface
Parameters:
- DATA_W, 32, address/data width (`DATA_BITS`)
- TYPE_W, 3, access-type width (`CACHE_TYPE_BITS`)
- CNT_W, 16, width of each saturating transaction counter

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  asynchronous, active-low reset (negedge clears all state)
- I_req  in  1  instruction-cache request, held until its I_wait is low
- I_addr  in  DATA_W  instruction-cache request address
- I_write  in  1  ignored; the I side is read-only
- I_type  in  TYPE_W  ignored; the I side always uses type 3'b111
- I_out  out  DATA_W  read data returned to the I-cache
- I_wait  out  1  I-cache stall
- D_req  in  1  data-cache request, held until its D_wait is low
- D_addr  in  DATA_W  data-cache request address
- D_write  in  1  1 = write, 0 = read
- D_in  in  DATA_W  write data
- D_type  in  TYPE_W  write byte/half/word type
- D_out  out  DATA_W  read data returned to the D-cache
- D_wait  out  1  D-cache stall
- m_read  out  1  read request to the Master
- m_write  out  1  write request to the Master
- m_type  out  TYPE_W  access type to the Master
- m_addr  out  DATA_W  address to the Master
- m_wdata  out  DATA_W  write data to the Master
- m_rdata  in  DATA_W  read data from the Master
- m_stall  in  1  Master busy; low = transaction complete this cycle
- cnt_i  out  CNT_W  completed I transactions
- cnt_d  out  CNT_W  completed D transactions

## Operation
- FSM states and transitions:
  - IDLE -> GNT_I when I_req is set and D_req is clear.
  - IDLE -> GNT_D when D_req is set and I_req is clear.
  - IDLE, both requests set: grant the side not in last_gnt.
  - GNT_I / GNT_D -> IDLE on the completion cycle (granted state and m_stall==0).
- last_gnt:
  - Updated to the granted side on every IDLE -> GNT_x transition.
  - Reset value is D, so I wins the first tie.
- On the grant edge, the block latches:
  - addr into m_addr.
  - D_in into m_wdata (D side only).
  - type into m_type: D_type on the D side, 3'b111 on the I side.
  - direction: m_write = D_write on the D side; m_read = 1 for I reads and D reads.
- m_read/m_write are asserted only in GNT_x and are low in IDLE.
- Requester wait:
  - Ungranted requester with req high: wait = 1.
  - Granted requester: wait = m_stall.
  - Any requester with req low: wait = 0.
- Return data:
  - I_out = m_rdata when GNT_I, else 0.
  - D_out = m_rdata when GNT_D, else 0.
- Requester dropping req while granted: the transaction still completes and no wait pulse is lost. The latched values keep driving the Master.
- Counters:
  - cnt_x increments on each completion cycle of side x.
  - Saturates at all-ones and does not wrap.
- Addresses are passed through unmodified; no width conversion.

## Timing
- Reset values:
  - state = IDLE, last_gnt = D.
  - m_read, m_write, m_addr, m_wdata, m_type = 0.
  - cnt_i, cnt_d = 0.
  - I_out, D_out = 0.
  - I_wait/D_wait are combinational: 0 while req is low.
- Arbitration latency: a request seen in IDLE at cycle 0 drives m_read/m_write from cycle 1.
- Completion:
  - In the cycle m_stall is low while granted, the requester sees wait = 0 with valid *_out.
  - State is IDLE at the next edge.
- Back-to-back:
  - After a completion there is exactly 1 IDLE cycle before the next grant.
  - Minimum transaction period is therefore 2 + Master latency.
- Simultaneous completion and new request: the new request is arbitrated in the following IDLE cycle, never in the completion cycle.
- Reset mid-transaction: the grant is abandoned and outputs return to reset values immediately. The Master is reset on the same rst.

## Test plan
- Reset: drive rst = 0 mid-GNT_D -> state IDLE, m_read = m_write = 0, cnt_i = cnt_d = 0, last_gnt = D.
- I read only:
  - Stimulus: I_req = 1, I_addr = 0x0000_0040; Master stalls 3 cycles and returns 0xDEADBEEF.
  - Expected: m_read = 1 from cycle 1, m_addr = 0x40, m_type = 3'b111, I_wait = 1 for 3 cycles, then I_out = 0xDEADBEEF with I_wait = 0; cnt_i = 1.
- Tie after reset:
  - Stimulus: I_req = D_req = 1 in the same cycle.
  - Expected: I granted first, D_wait = 1 throughout. D granted after 1 IDLE cycle, then I again if still pending (alternation I, D, I, D).
- D write:
  - Stimulus: D_req = 1, D_write = 1, D_addr = 0x1000_0004, D_in = 0x1234_5678, D_type = 3'b010.
  - Expected: m_write = 1, m_wdata = 0x12345678, m_type = 3'b010; inputs changed after the grant do not alter m_* until completion.
- Req drop: deassert D_req during GNT_D -> transaction still completes and cnt_d increments by 1.
- Saturation:
  - Stimulus: preload or run with CNT_W = 4 and complete 17 I transactions.
  - Expected: cnt_i = 15, no wrap.
